// File: rtl/wb_write_queue.sv
// Writeback queue between result producers and the regfile's single write port.
// Two-producer in-order enqueue, one retire per cycle, youngest-match forwarding.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_a_valid,
    output logic                       in_a_ready,
    input  logic [AW-1:0]              in_a_addr,
    input  logic [DW-1:0]              in_a_data,
    input  logic                       in_b_valid,
    output logic                       in_b_ready,
    input  logic [AW-1:0]              in_b_addr,
    input  logic [DW-1:0]              in_b_data,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_waddr,
    output logic [DW-1:0]              rf_wdata,
    input  logic [AW-1:0]              raddr1,
    output logic                       fwd1_hit,
    output logic [DW-1:0]              fwd1_data,
    input  logic [AW-1:0]              raddr2,
    output logic                       fwd2_hit,
    output logic [DW-1:0]              fwd2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_a;
    logic          push_b;
    logic          pop;
    logic [PW-1:0] slot_b;

    // Ready is a function of registered occupancy only; same-cycle pops are not credited.
    assign in_a_ready = (count <= CW'(DEPTH - 1));
    assign in_b_ready = (count <= CW'(DEPTH - 2));

    // Writes to r0 complete the handshake but never occupy a slot.
    assign push_a = in_a_valid && in_a_ready && (in_a_addr != '0) && !reset;
    assign push_b = in_b_valid && in_b_ready && (in_b_addr != '0) && !reset;
    assign pop    = (count != '0);
    assign slot_b = wr_ptr + PW'(push_a);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_a) begin
            mem_addr[wr_ptr] <= in_a_addr;
            mem_data[wr_ptr] <= in_a_data;
        end
        if (push_b) begin
            mem_addr[slot_b] <= in_b_addr;
            mem_data[slot_b] <= in_b_data;
        end
    end

    assign rf_we    = pop;
    assign rf_waddr = pop ? mem_addr[rd_ptr] : '0;
    assign rf_wdata = pop ? mem_data[rd_ptr] : '0;
    assign busy     = pop;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (raddr1 != '0 && mem_addr[rd_ptr + PW'(i)] == raddr1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = mem_data[rd_ptr + PW'(i)];
                end
                if (raddr2 != '0 && mem_addr[rd_ptr + PW'(i)] == raddr2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = mem_data[rd_ptr + PW'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios then random traffic, all outputs
// checked every cycle against a queue-based reference model.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_a_valid, in_a_ready;
    logic [AW-1:0] in_a_addr;
    logic [DW-1:0] in_a_data;
    logic          in_b_valid, in_b_ready;
    logic [AW-1:0] in_b_addr;
    logic [DW-1:0] in_b_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] raddr1, raddr2;
    logic          fwd1_hit, fwd2_hit;
    logic [DW-1:0] fwd1_data, fwd2_data;
    logic [CW-1:0] count;
    logic          busy;

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_addr(in_a_addr), .in_a_data(in_a_data),
        .in_b_valid(in_b_valid), .in_b_ready(in_b_ready), .in_b_addr(in_b_addr), .in_b_data(in_b_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .raddr1(raddr1), .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .raddr2(raddr2), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count), .busy(busy)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   max_count = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Forwarding reference: youngest queued entry with matching nonzero address.
    task automatic fwd_ref(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (ra != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a == ra) begin
                    hit  = 1'b1;
                    data = q[i].d;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int            n;
        logic          h1, h2;
        logic [DW-1:0] d1, d2;
        n = q.size();
        if (n > max_count) max_count = n;
        fwd_ref(raddr1, h1, d1);
        fwd_ref(raddr2, h2, d2);
        chk("rf_we",      64'(rf_we),      64'(n != 0));
        chk("rf_waddr",   64'(rf_waddr),   (n != 0) ? 64'(q[0].a) : 64'd0);
        chk("rf_wdata",   64'(rf_wdata),   (n != 0) ? 64'(q[0].d) : 64'd0);
        chk("count",      64'(count),      64'(n));
        chk("busy",       64'(busy),       64'(n != 0));
        chk("in_a_ready", 64'(in_a_ready), 64'(n <= DEPTH - 1));
        chk("in_b_ready", 64'(in_b_ready), 64'(n <= DEPTH - 2));
        chk("fwd1_hit",   64'(fwd1_hit),   64'(h1));
        chk("fwd1_data",  64'(fwd1_data),  64'(d1));
        chk("fwd2_hit",   64'(fwd2_hit),   64'(h2));
        chk("fwd2_data",  64'(fwd2_data),  64'(d2));
    endtask

    // One clock: snapshot the handshake, advance the model at the edge, then check.
    task automatic tick();
        int   n;
        logic acc_a, acc_b, rst;
        ent_t ea, eb;
        n     = q.size();
        rst   = reset;
        acc_a = in_a_valid && (n <= DEPTH - 1) && (in_a_addr != 0);
        acc_b = in_b_valid && (n <= DEPTH - 2) && (in_b_addr != 0);
        ea.a  = in_a_addr; ea.d = in_a_data;
        eb.a  = in_b_addr; eb.d = in_b_data;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (n != 0) void'(q.pop_front());
            if (acc_a) q.push_back(ea);
            if (acc_b) q.push_back(eb);
        end
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        in_a_valid = 1'b0; in_a_addr = '0; in_a_data = '0;
        in_b_valid = 1'b0; in_b_addr = '0; in_b_data = '0;
    endtask

    initial begin
        reset = 1'b1;
        raddr1 = '0;
        raddr2 = '0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_ready_b", 64'(in_b_ready), 64'd1);

        // single write
        in_a_valid = 1'b1; in_a_addr = 5'd3; in_a_data = 32'h11;
        raddr2 = 5'd3;
        tick();
        idle_inputs();
        chk("single_waddr", 64'(rf_waddr), 64'd3);
        chk("single_wdata", 64'(rf_wdata), 64'h11);
        tick();
        chk("single_busy_clear", 64'(busy), 64'd0);

        // dual push to the same register
        in_a_valid = 1'b1; in_a_addr = 5'd5; in_a_data = 32'hAA;
        in_b_valid = 1'b1; in_b_addr = 5'd5; in_b_data = 32'hBB;
        raddr1 = 5'd5;
        tick();
        idle_inputs();
        chk("dual_first_wdata", 64'(rf_wdata), 64'hAA);
        chk("dual_fwd_data",    64'(fwd1_data), 64'hBB);
        tick();
        chk("dual_second_wdata", 64'(rf_wdata), 64'hBB);
        tick();

        // r0 discard
        in_a_valid = 1'b1; in_a_addr = 5'd0; in_a_data = 32'hFFFF;
        raddr1 = 5'd0;
        tick();
        idle_inputs();
        chk("r0_count", 64'(count), 64'd0);
        chk("r0_fwd_hit", 64'(fwd1_hit), 64'd0);
        tick();

        // backpressure: both producers held valid
        for (int i = 0; i < 6; i++) begin
            in_a_valid = 1'b1; in_a_addr = AW'(2 * i + 1); in_a_data = 32'hA000 + i;
            in_b_valid = 1'b1; in_b_addr = AW'(2 * i + 2); in_b_data = 32'hB000 + i;
            raddr1 = AW'(2 * i + 1);
            raddr2 = AW'(2 * i);
            tick();
        end
        idle_inputs();
        repeat (5) tick();

        // wrap-around: alternating single-producer stream
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin
                in_a_valid = 1'b1; in_a_addr = AW'(i + 10); in_a_data = 32'hC00 + i;
            end else begin
                in_b_valid = 1'b1; in_b_addr = AW'(i + 10); in_b_data = 32'hD00 + i;
            end
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        // reset with three entries queued
        in_a_valid = 1'b1; in_a_addr = 5'd7; in_a_data = 32'h70;
        in_b_valid = 1'b1; in_b_addr = 5'd8; in_b_data = 32'h80;
        tick();
        in_a_addr = 5'd9;  in_a_data = 32'h90;
        in_b_addr = 5'd10; in_b_data = 32'hA0;
        tick();
        chk("prefill_count", 64'(count), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_we", 64'(rf_we), 64'd0);
        tick();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            reset      = ($urandom_range(0, 49) == 0);
            in_a_valid = $urandom_range(0, 1);
            in_a_addr  = AW'($urandom_range(0, 7));
            in_a_data  = $urandom;
            in_b_valid = $urandom_range(0, 1);
            in_b_addr  = AW'($urandom_range(0, 7));
            in_b_data  = $urandom;
            raddr1     = AW'($urandom_range(0, 7));
            raddr2     = AW'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        repeat (DEPTH + 1) tick();
        chk("drained_busy", 64'(busy), 64'd0);
        chk("max_count_bound", 64'(max_count <= DEPTH), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
